// File: rtl/pkt_pkg.sv
// Shared definitions for the packet formatter/unformatter pair:
// FSM state encoding, buffer sizing, checksum width and I/Q field positions.
package pkt_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } pkt_state_e;

  localparam int N_BUF     = 360;   // nominal samples per packet
  localparam int MAX_WORDS = 2048;  // limited by the 11-bit packet RAM address
  localparam int CSUM_W    = 32;

  // Sample layout in a 32-bit RAM / FIFO word.
  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  // One checksum step: add both 16-bit halves of a word, wrapping mod 2^32.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [31:0]       word);
    csum_add = acc + {16'h0000, word[I_MSB:I_LSB]} + {16'h0000, word[Q_MSB:Q_LSB]};
  endfunction

endpackage

// File: rtl/pkt_unform_if.sv
// Bus bundle between pkt_unform and its environment (control, packet RAM,
// channel FIFOs, verdict). The master modport is the unformatter itself.
//
// Handshake rules: start is a single-cycle request, sampled only while the
// unformatter is idle (otherwise dropped). wrreq0/wrreq1 are write strobes
// qualified by the FIFO status: a strobe is only raised in a cycle where the
// selected FIFO shows neither full nor af at/above the almost-full level, so
// every strobe is one accepted word. end_rx is a one-cycle completion pulse;
// crc_ok/crc_err change only together with it.
interface pkt_unform_if;
  import pkt_pkg::*;

  logic        start;
  logic [7:0]  channel;
  logic [15:0] nbuf;
  logic [31:0] crc_buf;
  logic [10:0] adr_ram;
  logic [31:0] q_ram;
  logic [31:0] fifo_d;
  logic        wrreq0;
  logic        wrreq1;
  logic [8:0]  af0;
  logic [8:0]  af1;
  logic        full0;
  logic        full1;
  logic        end_rx;
  logic        crc_ok;
  logic        crc_err;
  logic [15:0] err_cnt;
  pkt_state_e  dbg_state;

  modport master (
    input  start, channel, nbuf, crc_buf, q_ram, af0, af1, full0, full1,
    output adr_ram, fifo_d, wrreq0, wrreq1, end_rx, crc_ok, crc_err, err_cnt,
           dbg_state
  );

  modport slave (
    output start, channel, nbuf, crc_buf, q_ram, af0, af1, full0, full1,
    input  adr_ram, fifo_d, wrreq0, wrreq1, end_rx, crc_ok, crc_err, err_cnt,
           dbg_state
  );

endinterface

// File: rtl/pkt_csum_acc.sv
// Packet checksum accumulator: clear at packet start, then add the I and Q
// halves of each word read from packet RAM, modulo 2^32.
module pkt_csum_acc
  import pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [31:0]       din,
  output logic [CSUM_W-1:0] acc
);

  // Clear has priority so a new packet never inherits an old sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= csum_add(acc, din);
    end
  end

endmodule

// File: rtl/pkt_unform.sv
// Packet unformatter: reads a completed packet from packet RAM, streams its
// I/Q words to FIFO 0 or 1, checks the 16+16 checksum and reports a verdict.
// Three clocks per word (RD, WAIT, WR); stalls only in WR on FIFO back-pressure.
// Build option: define PKT_UNFORM_ERRCNT_EN to build the failed-packet counter;
// without it err_cnt is constant zero.
module pkt_unform
  import pkt_pkg::*;
#(
  parameter int         MAX_WORDS   = pkt_pkg::MAX_WORDS,
  parameter logic [8:0] FIFO_AF_LVL = 9'd500
) (
  input logic          clk,
  input logic          rst,
  pkt_unform_if.master bus
);

  localparam logic [13:0] MAX_W = 14'(MAX_WORDS);

  pkt_state_e        state;
  pkt_state_e        state_n;
  logic [7:0]        ch_q;
  logic [13:0]       nwords_q;
  logic [CSUM_W-1:0] crc_q;
  logic              len_err_q;
  logic [11:0]       addr_q;
  logic [11:0]       addr_nxt;
  logic [31:0]       fifo_d_q;
  logic              verdict_ok_q;
  logic              end_rx_q;
  logic              crc_ok_q;
  logic              crc_err_q;
  logic [CSUM_W-1:0] acc;
  logic              acc_clr;
  logic              acc_en;
  logic              addr_inc;
  logic              wr0;
  logic              wr1;
  logic              stall0;
  logic              stall1;
  logic              wr_go;
  logic              len_bad;

  // Length is rejected before any RAM access: empty, not word-aligned, or too long.
  assign len_bad  = (bus.nbuf == 16'd0) || (bus.nbuf[1:0] != 2'b00) ||
                    (bus.nbuf[15:2] > MAX_W);
  assign stall0   = bus.full0 || (bus.af0 >= FIFO_AF_LVL);
  assign stall1   = bus.full1 || (bus.af1 >= FIFO_AF_LVL);
  // Channels above 1 have no FIFO: the word is dropped and nothing can stall it.
  assign wr_go    = (ch_q == 8'd0) ? !stall0 :
                    (ch_q == 8'd1) ? !stall1 : 1'b1;
  assign addr_nxt = addr_q + 12'd1;

  pkt_csum_acc u_csum (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (bus.q_ram),
    .acc (acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic plus the per-cycle strobes (write, accumulate, advance).
  always_comb begin
    state_n  = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    addr_inc = 1'b0;
    wr0      = 1'b0;
    wr1      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          acc_clr = 1'b1;
          state_n = len_bad ? S_CHK : S_RD;
        end
      end
      S_RD:   state_n = S_WAIT;
      S_WAIT: begin
        acc_en  = 1'b1;
        state_n = S_WR;
      end
      S_WR: begin
        if (wr_go) begin
          wr0      = (ch_q == 8'd0);
          wr1      = (ch_q == 8'd1);
          addr_inc = 1'b1;
          state_n  = ({2'b00, addr_nxt} < nwords_q) ? S_RD : S_CHK;
        end
      end
      S_CHK:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Packet context, RAM address, FIFO data register and verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q         <= '0;
      nwords_q     <= '0;
      crc_q        <= '0;
      len_err_q    <= 1'b0;
      addr_q       <= '0;
      fifo_d_q     <= '0;
      verdict_ok_q <= 1'b0;
      end_rx_q     <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
    end else begin
      end_rx_q <= (state == S_DONE);
      if (state == S_IDLE && bus.start) begin
        ch_q      <= bus.channel;
        nwords_q  <= bus.nbuf[15:2];
        crc_q     <= bus.crc_buf;
        len_err_q <= len_bad;
        addr_q    <= '0;
      end
      if (state == S_WAIT) fifo_d_q <= bus.q_ram;
      if (addr_inc) addr_q <= addr_nxt;
      if (state == S_CHK) begin
        verdict_ok_q <= !len_err_q && (ch_q <= 8'd1) && (acc == crc_q);
      end
      // Verdict flips together with end_rx so it is stable between pulses.
      if (state == S_DONE) begin
        crc_ok_q  <= verdict_ok_q;
        crc_err_q <= !verdict_ok_q;
      end
    end
  end

`ifdef PKT_UNFORM_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Failed-packet counter, saturating so it never wraps back to a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state == S_DONE && !verdict_ok_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 16'h0000;
`endif

  assign bus.adr_ram   = addr_q[10:0];
  assign bus.fifo_d    = fifo_d_q;
  assign bus.wrreq0    = wr0;
  assign bus.wrreq1    = wr1;
  assign bus.end_rx    = end_rx_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_pkt_unform.sv
// Bench for pkt_unform: directed packets, a word/verdict scoreboard and a
// negedge monitor that pops expectations whenever the DUT writes or ends.
module tb_pkt_unform;
  import pkt_pkg::*;

  localparam int W = 33;  // {wrreq1, fifo_d}

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  pkt_unform_if bus();

  pkt_unform dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Packet RAM model: one-clock read latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) bus.q_ram <= mem[bus.adr_ram];

  logic [W-1:0] exp_q[$];
  logic [17:0]  exp_v_q[$];  // {crc_ok, crc_err, err_cnt}
  logic [15:0]  exp_err = 16'h0000;
  int n_vec = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_end = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compare every FIFO write and every completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dbg_state == S_RD) n_rd++;
      if (bus.wrreq0 || bus.wrreq1) begin
        n_wr++;
        check("wrreq_excl", {63'd0, bus.wrreq0 & bus.wrreq1}, 64'd0);
        check("wr_while_stalled",
              {63'd0, (bus.wrreq0 && (bus.full0 || bus.af0 >= 9'd500)) ||
                      (bus.wrreq1 && (bus.full1 || bus.af1 >= 9'd500))}, 64'd0);
        if (exp_q.size() == 0) fail_now("unexpected_wrreq");
        else check("fifo_word", {31'd0, bus.wrreq1, bus.fifo_d}, {31'd0, exp_q.pop_front()});
      end
      if (bus.end_rx) begin
        n_end++;
        if (exp_v_q.size() == 0) fail_now("unexpected_end_rx");
        else check("verdict", {46'd0, bus.crc_ok, bus.crc_err, bus.err_cnt},
                   {46'd0, exp_v_q.pop_front()});
        check("words_left", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Words i = {i, 16'h0001}: checksum = sum(0..359) + 360 = 64620 + 360 = 64980.
  task automatic fill_nominal();
    for (int i = 0; i < 2048; i++) mem[i] = {16'(i), 16'h0001};
  endtask

  // All-ones words: 2048 * (0xFFFF + 0xFFFF) = 2048 * 0x1FFFE = 0x0FFF_F000.
  task automatic fill_ones();
    for (int i = 0; i < 2048; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  // One packet. bp: 0 none, 1 full0 for 50 clk, 2 af1=500 for 50 clk.
  // lat_exp counts clocks from the cycle start is high to the cycle end_rx is high (0 = unchecked).
  task automatic run_pkt(input logic [7:0] ch, input logic [15:0] nbuf, input logic [31:0] crc,
                         input bit exp_ok, input bit push_words, input int lat_exp,
                         input int exp_rd, input int bp, input bit spur);
    int lat;
    int rd0;
    if (push_words)
      for (int i = 0; i < int'(nbuf[15:2]); i++) exp_q.push_back({ch[0], mem[i]});
`ifdef PKT_UNFORM_ERRCNT_EN
    if (!exp_ok && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
`endif
    exp_v_q.push_back({exp_ok, !exp_ok, exp_err});
    rd0 = n_rd;
    bus.channel = ch;
    bus.nbuf    = nbuf;
    bus.crc_buf = crc;
    bus.start   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (spur && lat == 200) begin
        bus.start = 1'b1; bus.channel = 8'd1; bus.nbuf = 16'd4;
      end
      if (spur && lat == 201) bus.start = 1'b0;
      if (bp == 1 && lat == 600) bus.full0 = 1'b1;
      if (bp == 1 && lat == 650) bus.full0 = 1'b0;
      if (bp == 2 && lat == 300) bus.af1 = 9'd500;
      if (bp == 2 && lat == 350) bus.af1 = 9'd499;
    end while (!bus.end_rx && lat < 20000);
    if (!bus.end_rx) fail_now("end_rx_timeout");
    else if (lat_exp != 0) check("latency", 64'(lat), 64'(lat_exp));
    check("rd_cycles", 64'(n_rd - rd0), 64'(exp_rd));
    idle(10);
  endtask

  task automatic check_zero_outs(input string name);
    check(name, {16'd0, bus.adr_ram, bus.fifo_d, bus.wrreq0, bus.wrreq1,
                 bus.end_rx, bus.crc_ok, bus.crc_err}, 64'd0);
    check({name, "_err_cnt"}, {48'd0, bus.err_cnt}, 64'd0);
    check({name, "_state"}, {61'd0, bus.dbg_state}, {61'd0, S_IDLE});
  endtask

  initial begin
    int base;
    int end0;
    int k;
    bus.start = 1'b0; bus.channel = '0; bus.nbuf = '0; bus.crc_buf = '0;
    bus.af0 = 9'd499; bus.af1 = 9'd499;  // one below the stall level
    bus.full0 = 1'b0; bus.full1 = 1'b0;
    fill_nominal();

    // Reset.
    repeat (3) @(posedge clk);
    #1;
    check_zero_outs("reset");
    rst = 1'b0;
    idle(2);

    // Nominal, with a start pulse mid-packet that must be dropped.
    run_pkt(8'd0, 16'd1440, 32'd64980, 1'b1, 1'b1, 1083, 360, 0, 1'b1);
    // Bad checksum on channel 1, with an af1 stall.
    run_pkt(8'd1, 16'd1440, 32'd64981, 1'b0, 1'b1, 0, 360, 2, 1'b0);
    // Back-pressure via full0.
    run_pkt(8'd0, 16'd1440, 32'd64980, 1'b1, 1'b1, 0, 360, 1, 1'b0);
    // Length errors: misaligned, empty, one word too long.
    run_pkt(8'd0, 16'd1442, 32'd64980, 1'b0, 1'b0, 3, 0, 0, 1'b0);
    run_pkt(8'd0, 16'd0,    32'd0,     1'b0, 1'b0, 3, 0, 0, 1'b0);
    run_pkt(8'd1, 16'd8196, 32'd0,     1'b0, 1'b0, 3, 0, 0, 1'b0);
    // Channel 2: reads happen, no writes, verdict is an error.
    run_pkt(8'd2, 16'd1440, 32'd64980, 1'b0, 1'b0, 1083, 360, 0, 1'b0);
    // Maximum length, all-ones words.
    fill_ones();
    run_pkt(8'd0, 16'd8192, 32'h0FFF_F000, 1'b1, 1'b1, 6147, 2048, 0, 1'b0);

    // Reset at word 100 of a packet, then a fresh packet.
    fill_nominal();
    for (int i = 0; i < N_BUF; i++) exp_q.push_back({1'b0, mem[i]});
    base = n_wr;
    end0 = n_end;
    bus.channel = 8'd0; bus.nbuf = 16'd1440; bus.crc_buf = 32'd64980;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (n_wr < base + 100 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_wr < base + 100) fail_now("reset_test_wait_timeout");
    rst = 1'b1;
    idle(2);
    exp_q.delete();
    exp_v_q.delete();
    exp_err = 16'h0000;
    check_zero_outs("mid_pkt_reset");
    rst = 1'b0;
    idle(1100);
    check("abandoned_end_rx", 64'(n_end - end0), 64'd0);
    run_pkt(8'd0, 16'd1440, 32'd64980, 1'b1, 1'b1, 1083, 360, 0, 1'b0);

    check("queue_empty", 64'(exp_q.size() + exp_v_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
